// File: rtl/cv32e40p_obi_sram_bridge_pkg.sv
// Shared types for the OBI-to-SRAM bridge.
//   obi_rsp_meta_t  : per-transfer response tag {valid, we, err}
//   obi_gnt_state_e : grant FSM states
//   WAIT_CNT_W      : width of the grant-wait counter
//   in_window()     : unsigned window check, wrap below the base counts as outside
package cv32e40p_obi_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef struct packed {
        logic valid;
        logic we;
        logic err;
    } obi_rsp_meta_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } obi_gnt_state_e;

    // Subtraction in 32 bits makes addresses below the base wrap to huge offsets.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] span);
        logic [31:0] offset;
        offset = addr - base;
        return (offset < span);
    endfunction

endpackage

// File: rtl/cv32e40p_obi_sram_bridge_if.sv
// OBI data bus plus SRAM macro port, bundled for the bridge.
//   slave  : bridge side (takes OBI requests, drives the SRAM)
//   master : core/bench side (issues OBI requests, models the SRAM)
// Signal names follow the bridge's port list (suffix = direction seen by the bridge).
interface cv32e40p_obi_sram_bridge_if #(
    parameter int MEM_WORDS = 4096
);
    localparam int AW = $clog2(MEM_WORDS);

    logic          req_i;
    logic          gnt_o;
    logic [31:0]   addr_i;
    logic          we_i;
    logic [3:0]    be_i;
    logic [31:0]   wdata_i;
    logic          rvalid_o;
    logic [31:0]   rdata_o;
    logic          err_o;
    logic          mem_busy_i;
    logic          mem_en_o;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, mem_busy_i, mem_rdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
               mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, mem_busy_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
               mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/cv32e40p_obi_sram_bridge_chk.sv
// Protocol checker for the bridge's OBI slave port.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   i_state      : grant FSM state
//   i_req, i_gnt : OBI request and grant
module cv32e40p_obi_sram_bridge_chk
    import cv32e40p_obi_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  obi_gnt_state_e i_state,
    input  logic           i_req,
    input  logic           i_gnt
);

    // A request may not be withdrawn while it is waiting for its grant.
    a_req_held : assert property (@(posedge clk_i) disable iff (rst_i)
        (i_state == STALL) |-> i_req);

    // Grant is only ever an answer to a request.
    a_gnt_has_req : assert property (@(posedge clk_i) disable iff (rst_i)
        i_gnt |-> i_req);

endmodule

// File: rtl/cv32e40p_obi_sram_bridge_rsp_pipe.sv
// Response pipeline: stage 0 holds the tag of the transfer granted last cycle
// while the SRAM presents its read data; DEPTH further register stages follow.
//   i_clk, i_rst  : clock, asynchronous active-high clear
//   i_meta        : tag of the transfer granted this cycle (valid=0 when none)
//   i_mem_rdata   : SRAM read data (valid the cycle after a read enable)
//   o_valid/o_err/o_rdata : OBI response
module cv32e40p_obi_rsp_pipe
    import cv32e40p_obi_pkg::*;
#(
    parameter int DEPTH = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  obi_rsp_meta_t i_meta,
    input  logic [31:0]   i_mem_rdata,
    output logic          o_valid,
    output logic          o_err,
    output logic [31:0]   o_rdata
);

    obi_rsp_meta_t r_s0;
    logic [31:0]   w_s0_data;

    // Stage 0 tag register, loaded on every cycle (bubbles carry valid=0).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s0 <= '0;
        end else begin
            r_s0 <= i_meta;
        end
    end

    // Only in-range reads carry SRAM data; writes and errors return zero.
    always_comb begin
        if (r_s0.valid && !r_s0.we && !r_s0.err) begin
            w_s0_data = i_mem_rdata;
        end else begin
            w_s0_data = 32'h0000_0000;
        end
    end

    generate
        if (DEPTH == 0) begin : g_direct
            // No extra latency: respond straight from stage 0.
            always_comb begin
                o_valid = r_s0.valid;
                o_err   = r_s0.valid & r_s0.err;
                o_rdata = w_s0_data;
            end
        end else begin : g_pipe
            obi_rsp_meta_t r_meta [DEPTH];
            logic [31:0]   r_data [DEPTH];

            // Delay line; a reset drops every in-flight response.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        r_meta[k] <= '0;
                        r_data[k] <= 32'h0000_0000;
                    end
                end else begin
                    r_meta[0] <= r_s0;
                    r_data[0] <= w_s0_data;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_meta[k] <= r_meta[k-1];
                        r_data[k] <= r_data[k-1];
                    end
                end
            end

            // Response taken from the last stage.
            always_comb begin
                o_valid = r_meta[DEPTH-1].valid;
                o_err   = r_meta[DEPTH-1].valid & r_meta[DEPTH-1].err;
                o_rdata = r_data[DEPTH-1];
            end
        end
    endgenerate

endmodule

// File: rtl/cv32e40p_obi_sram_bridge.sv
// OBI data-port slave that fronts a single-port synchronous SRAM (1-cycle read).
// Grants after an optional wait, rejects out-of-window addresses with err, and
// delays every response by 1+RSP_LAT cycles after its grant.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : OBI request/response and SRAM port (slave modport)
module cv32e40p_obi_sram_bridge
    import cv32e40p_obi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          MEM_WORDS = 4096,
    parameter int          GNT_WAIT  = 0,
    parameter int          RSP_LAT   = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    cv32e40p_obi_sram_bridge_if.slave bus
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN      = 32'(MEM_WORDS * 4);
    localparam logic        GW_ZERO   = (GNT_WAIT == 0);

    obi_gnt_state_e          r_state;
    obi_gnt_state_e          w_state_nxt;
    logic [WAIT_CNT_W-1:0]   r_wait_cnt;
    logic [WAIT_CNT_W-1:0]   w_wait_cnt_nxt;
    logic                    w_wait_done;
    logic                    w_gnt;
    logic                    w_in_range;
    logic                    w_mem_en;
    logic [31:0]             w_offset;
    obi_rsp_meta_t           w_meta;
    logic                    w_rvalid;
    logic                    w_err;
    logic [31:0]             w_rdata;

    assign w_offset    = bus.addr_i - ADDR_BASE;
    assign w_in_range  = in_window(bus.addr_i, ADDR_BASE, SPAN);
    assign w_wait_done = (int'(r_wait_cnt) >= GNT_WAIT);

    // Grant FSM state and wait counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next state and combinational grant; the counter saturates so a long
    // busy period cannot wrap it back below the wait threshold.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_gnt          = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.req_i) begin
                    if (!bus.mem_busy_i && GW_ZERO) begin
                        w_gnt = 1'b1;
                    end else begin
                        w_state_nxt    = STALL;
                        w_wait_cnt_nxt = 4'd1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            STALL: begin
                if (!bus.req_i) begin
                    // Illegal withdrawal: recover rather than hang.
                    w_state_nxt    = IDLE;
                    w_wait_cnt_nxt = 4'd0;
                end else if (w_wait_done && !bus.mem_busy_i) begin
                    w_gnt          = 1'b1;
                    w_state_nxt    = IDLE;
                    w_wait_cnt_nxt = 4'd0;
                end else if (w_wait_done) begin
                    w_wait_cnt_nxt = r_wait_cnt;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_wait_cnt_nxt = 4'd0;
            end
        endcase
    end

    // Response tag for the transfer granted this cycle.
    always_comb begin
        w_meta.valid = w_gnt;
        w_meta.we    = w_gnt & bus.we_i;
        w_meta.err   = w_gnt & ~w_in_range;
    end

    assign w_mem_en        = w_gnt & w_in_range;
    assign bus.gnt_o       = w_gnt;
    assign bus.mem_en_o    = w_mem_en;
    assign bus.mem_we_o    = w_mem_en & bus.we_i;
    assign bus.mem_be_o    = w_mem_en ? bus.be_i : 4'h0;
    assign bus.mem_addr_o  = w_offset[2 +: AW];
    assign bus.mem_wdata_o = bus.wdata_i;

    cv32e40p_obi_rsp_pipe #(
        .DEPTH (RSP_LAT)
    ) u_rsp_pipe (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_meta      (w_meta),
        .i_mem_rdata (bus.mem_rdata_i),
        .o_valid     (w_rvalid),
        .o_err       (w_err),
        .o_rdata     (w_rdata)
    );

    assign bus.rvalid_o = w_rvalid;
    assign bus.err_o    = w_err;
    assign bus.rdata_o  = w_rdata;

    cv32e40p_obi_sram_bridge_chk u_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_state (r_state),
        .i_req   (bus.req_i),
        .i_gnt   (w_gnt)
    );

endmodule

// File: tb/tb_cv32e40p_obi_sram_bridge.sv
// Bench for cv32e40p_obi_sram_bridge: three instances with different
// base/wait/latency settings, each with its own SRAM macro model, driven by
// directed transfers and checked every cycle against a transaction-level model.
module tb_cv32e40p_obi_sram_bridge;

    localparam int          MW   = 64;
    localparam int          NI   = 3;
    localparam logic [31:0] SPAN = 32'(MW * 4);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_s [NI];
    logic        we_s  [NI];
    logic        busy_s[NI];
    logic [3:0]  be_s  [NI];
    logic [31:0] addr_s[NI];
    logic [31:0] wdata_s[NI];

    logic        gnt_w   [NI];
    logic        rvalid_w[NI];
    logic        err_w   [NI];
    logic        men_w   [NI];
    logic        mwe_w   [NI];
    logic [3:0]  mbe_w   [NI];
    logic [5:0]  maddr_w [NI];
    logic [31:0] rdata_w [NI];
    logic [31:0] mwdata_w[NI];
    logic [31:0] mrdata_r[NI];
    logic [31:0] sram    [NI][MW];

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] base_of(input int i);
        return (i == 1) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction
    function automatic int gw_of(input int i);
        return (i == 2) ? 3 : 0;
    endfunction
    function automatic int rl_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] b);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = b[k] ? n[8*k +: 8] : o[8*k +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        cv32e40p_obi_sram_bridge_if #(.MEM_WORDS(MW)) bus ();
        assign bus.req_i       = req_s[g];
        assign bus.addr_i      = addr_s[g];
        assign bus.we_i        = we_s[g];
        assign bus.be_i        = be_s[g];
        assign bus.wdata_i     = wdata_s[g];
        assign bus.mem_busy_i  = busy_s[g];
        assign bus.mem_rdata_i = mrdata_r[g];
        assign gnt_w[g]        = bus.gnt_o;
        assign rvalid_w[g]     = bus.rvalid_o;
        assign rdata_w[g]      = bus.rdata_o;
        assign err_w[g]        = bus.err_o;
        assign men_w[g]        = bus.mem_en_o;
        assign mwe_w[g]        = bus.mem_we_o;
        assign mbe_w[g]        = bus.mem_be_o;
        assign maddr_w[g]      = bus.mem_addr_o;
        assign mwdata_w[g]     = bus.mem_wdata_o;

        cv32e40p_obi_sram_bridge #(
            .ADDR_BASE ((g == 1) ? 32'h0000_1000 : 32'h0000_0000),
            .MEM_WORDS (MW),
            .GNT_WAIT  ((g == 2) ? 3 : 0),
            .RSP_LAT   ((g == 0) ? 0 : ((g == 1) ? 2 : 1))
        ) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus)
        );
    end

    // SRAM macros: write-first, 1-cycle read, contents reloaded while in reset.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                for (int j = 0; j < MW; j++) sram[i][j] <= 32'(j + 1);
            end else if (men_w[i]) begin
                if (mwe_w[i]) begin
                    sram[i][maddr_w[i]]  <= merge(sram[i][maddr_w[i]], mwdata_w[i], mbe_w[i]);
                    mrdata_r[i]          <= merge(sram[i][maddr_w[i]], mwdata_w[i], mbe_w[i]);
                end else begin
                    mrdata_r[i] <= sram[i][maddr_w[i]];
                end
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d: got %h expected %h", nm, i, act, exp);
        end
    endtask

    // Reference model state and observation log.
    int          k_m    [NI];
    logic        ev     [NI][8];
    logic        ee     [NI][8];
    logic [31:0] ed     [NI][8];
    logic [31:0] refm   [NI][MW];
    int          cyc = 0;
    int          gnt_cyc[NI];
    int          rv_cyc [NI];
    int          rv_cnt [NI];
    logic [31:0] last_rd[NI];
    logic        last_er[NI];
    logic [31:0] rlog   [NI][8];

    // Compare process: predicts grant, SRAM strobes and responses every cycle.
    initial begin
        int s, kk, ds;
        logic eg, inr;
        logic [31:0] off;
        for (int i = 0; i < NI; i++) begin
            k_m[i] = 0; gnt_cyc[i] = 0; rv_cyc[i] = 0; rv_cnt[i] = 0;
            last_rd[i] = 32'h0; last_er[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            s = cyc % 8;
            for (int i = 0; i < NI; i++) begin
                if (rst) begin
                    chk("rst_rvalid", i, 32'(rvalid_w[i]), 32'd0);
                    chk("rst_gnt", i, 32'(gnt_w[i]), 32'd0);
                    chk("rst_mem_en", i, 32'(men_w[i]), 32'd0);
                    k_m[i] = 0;
                    for (int j = 0; j < 8; j++) ev[i][j] = 1'b0;
                    for (int j = 0; j < MW; j++) refm[i][j] = 32'(j + 1);
                end else begin
                    kk  = req_s[i] ? k_m[i] + 1 : 0;
                    eg  = req_s[i] && !busy_s[i] && (kk - 1 >= gw_of(i));
                    off = addr_s[i] - base_of(i);
                    inr = off < SPAN;
                    chk("gnt", i, 32'(gnt_w[i]), 32'(eg));
                    chk("mem_en", i, 32'(men_w[i]), 32'(eg && inr));
                    if (eg && inr) begin
                        chk("mem_addr", i, {26'b0, maddr_w[i]}, {26'b0, off[7:2]});
                        chk("mem_we", i, 32'(mwe_w[i]), 32'(we_s[i]));
                        chk("mem_be", i, {28'b0, mbe_w[i]}, {28'b0, be_s[i]});
                        if (we_s[i]) chk("mem_wdata", i, mwdata_w[i], wdata_s[i]);
                    end
                    chk("rvalid", i, 32'(rvalid_w[i]), 32'(ev[i][s]));
                    if (ev[i][s]) begin
                        chk("err", i, 32'(err_w[i]), 32'(ee[i][s]));
                        chk("rdata", i, rdata_w[i], ed[i][s]);
                    end
                    ev[i][s] = 1'b0;
                    if (eg) begin
                        ds = (cyc + 1 + rl_of(i)) % 8;
                        ev[i][ds] = 1'b1;
                        ee[i][ds] = !inr;
                        ed[i][ds] = (inr && !we_s[i]) ? refm[i][off[7:2]] : 32'h0;
                        if (inr && we_s[i]) refm[i][off[7:2]] = merge(refm[i][off[7:2]], wdata_s[i], be_s[i]);
                    end
                    k_m[i] = eg ? 0 : kk;
                    if (gnt_w[i]) gnt_cyc[i] = cyc;
                    if (rvalid_w[i]) begin
                        rv_cyc[i]  = cyc;
                        last_rd[i] = rdata_w[i];
                        last_er[i] = err_w[i];
                        rlog[i][rv_cnt[i] % 8] = rdata_w[i];
                        rv_cnt[i]++;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic xfer(input int i, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output int n);
        req_s[i] = 1'b1; addr_s[i] = a; we_s[i] = w; be_s[i] = b; wdata_s[i] = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (gnt_w[i]) break;
            n++;
            if (n > 40) begin
                checks++; failures++;
                $display("FAIL gnt_timeout inst%0d: got no grant expected grant within 40 cycles", i);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int i);
        req_s[i] = 1'b0; we_s[i] = 1'b0; be_s[i] = 4'h0; addr_s[i] = 32'h0; wdata_s[i] = 32'h0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1);
    end

    initial begin
        int n, c0;
        for (int i = 0; i < NI; i++) begin
            idle(i);
            busy_s[i] = 1'b0;
        end
        settle(3);
        rst = 1'b0;
        settle(1);

        // Write then read the same word back to back; immediate grants.
        xfer(0, 32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, n);
        chk("t1_wr_wait", 0, n, 32'd0);
        xfer(0, 32'h10, 1'b0, 4'hF, 32'h0, n);
        chk("t1_rd_wait", 0, n, 32'd0);
        idle(0); settle(3);
        chk("t1_rdata", 0, last_rd[0], 32'hDEAD_BEEF);
        chk("t1_err", 0, 32'(last_er[0]), 32'd0);
        chk("t1_lat", 0, rv_cyc[0] - gnt_cyc[0], 32'd1);

        // Partial byte-enable write: word 8 preloaded with 9.
        xfer(0, 32'h20, 1'b1, 4'b0101, 32'hAABB_CCDD, n);
        xfer(0, 32'h20, 1'b0, 4'hF, 32'h0, n);
        idle(0); settle(3);
        chk("be_rdata", 0, last_rd[0], 32'h00BB_00DD);

        // Window edges.
        xfer(0, 32'hFC, 1'b0, 4'hF, 32'h0, n);
        idle(0); settle(3);
        chk("top_word", 0, last_rd[0], 32'd64);
        xfer(0, 32'h100, 1'b0, 4'hF, 32'h0, n);
        idle(0); settle(3);
        chk("above_err", 0, 32'(last_er[0]), 32'd1);
        chk("above_rdata", 0, last_rd[0], 32'd0);
        xfer(0, 32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0, n);
        idle(0); settle(3);
        chk("below_err", 0, 32'(last_er[0]), 32'd1);
        chk("below_rdata", 0, last_rd[0], 32'd0);

        // SRAM busy for five cycles of a pending request.
        busy_s[0] = 1'b1;
        fork
            begin
                repeat (5) @(posedge clk);
                #1 busy_s[0] = 1'b0;
            end
        join_none
        xfer(0, 32'h8, 1'b0, 4'hF, 32'h0, n);
        idle(0);
        chk("busy_wait", 0, n, 32'd5);
        settle(3);
        chk("busy_rdata", 0, last_rd[0], 32'd3);

        // Grant wait of three cycles, one extra response stage.
        xfer(2, 32'h8, 1'b0, 4'hF, 32'h0, n);
        idle(2);
        chk("gw3_wait", 2, n, 32'd3);
        settle(4);
        chk("gw3_rdata", 2, last_rd[2], 32'd3);
        chk("gw3_lat", 2, rv_cyc[2] - gnt_cyc[2], 32'd2);

        // Back-to-back reads with two extra response stages.
        c0 = rv_cnt[1];
        for (int j = 0; j < 4; j++) begin
            xfer(1, 32'h1000 + 32'(4 * j), 1'b0, 4'hF, 32'h0, n);
            chk("b2b_wait", 1, n, 32'd0);
        end
        idle(1); settle(6);
        for (int j = 0; j < 4; j++) chk("b2b_rdata", 1, rlog[1][(c0 + j) % 8], 32'(j + 1));
        chk("b2b_lat", 1, rv_cyc[1] - gnt_cyc[1], 32'd3);
        xfer(1, 32'h0FFC, 1'b0, 4'hF, 32'h0, n);
        idle(1); settle(5);
        chk("i1_below_err", 1, 32'(last_er[1]), 32'd1);

        // Reset with two reads in flight.
        c0 = rv_cnt[1];
        xfer(1, 32'h1004, 1'b0, 4'hF, 32'h0, n);
        xfer(1, 32'h1008, 1'b0, 4'hF, 32'h0, n);
        idle(1);
        rst = 1'b1;
        settle(2);
        rst = 1'b0;
        settle(6);
        chk("rst_dropped", 1, rv_cnt[1], c0);
        xfer(1, 32'h100C, 1'b0, 4'hF, 32'h0, n);
        idle(1); settle(5);
        chk("post_rst_cnt", 1, rv_cnt[1], c0 + 1);
        chk("post_rst_rdata", 1, last_rd[1], 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
